// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and matrix slicing helpers for the
// systolic_array result path. Element [r][c] of a matrix lives in the byte
// at flat index r*ROWS+c counted from the MSB end, so row 0 occupies the top
// ROW_W bits and element 0 of each row is that row's most significant byte.
package systolic_pkg;

    localparam int ROWS      = 4;
    localparam int ELEM_W    = 8;
    localparam int ROW_W     = ROWS * ELEM_W;
    localparam int MAT_W     = ROWS * ROW_W;
    localparam int ROW_IDX_W = $clog2(ROWS);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // LSB position of row 'row' inside a flat matrix word.
    function automatic int row_lsb(input int row);
        return MAT_W - (row + 1) * ROW_W;
    endfunction

    // LSB position of element [row][col] inside a flat matrix word.
    function automatic int elem_lsb(input int row, input int col);
        return MAT_W - row * ROW_W - (col + 1) * ELEM_W;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// DEPTH-entry register FIFO holding complete result matrices.
// A push is accepted when the FIFO has room, or when it is full and the head
// is popped in the same cycle (the freed slot is reused immediately).
// next_head exposes the entry behind the head so the streamer can switch
// matrices without a bubble cycle.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [W-1:0] next_head,
    output logic         full,
    output logic         has_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] rptr_nx;
    logic             pop_ok;
    logic             push_ok;

    assign full      = (count_q == CNT_FULL);
    assign has_next  = (count_q > CNT_ONE);
    assign pop_ok    = pop && (count_q != '0);
    assign push_ok   = push && (!full || pop_ok);
    assign rptr_nx   = rptr_q + PTR_ONE;
    assign head      = mem_q[rptr_q];
    assign next_head = mem_q[rptr_nx];

    // Next-state for pointers and occupancy count.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_nx;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Matrix storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; clearing the pointers empties the FIFO and stale entries are never read.
        if (push_ok) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/result_streamer.sv
// result_streamer: buffers ROWSxROWS result matrices from systolic_array and
// streams them one row (or column) per beat over a valid/ready interface.
// Build option: define RESULT_TRANSPOSE_EN to stream columns instead of rows
// (beat k = {elem[0][k], ..., elem[ROWS-1][k]}); out_row then indexes columns.
module result_streamer
    import systolic_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MAT_W-1:0]     result,
    input  logic                 valid_out,
    output logic [ROW_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [ROW_IDX_W-1:0] out_row,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
    localparam logic [ROW_IDX_W-1:0] ROW_ONE  = ROW_IDX_W'(1);

    state_e                 state_q, state_d;
    logic [ROW_IDX_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]       data_q, data_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic [MAT_W-1:0]       fifo_head;
    logic [MAT_W-1:0]       fifo_next_head;
    logic                   fifo_full;
    logic                   fifo_has_next;
    logic                   beat;
    logic                   last_beat;
    logic                   capture;
    logic                   drop;

    // Extract beat 'idx' of a matrix: a row, or a column in transpose builds.
    function automatic logic [ROW_W-1:0] beat_of(input logic [MAT_W-1:0]     mat,
                                                 input logic [ROW_IDX_W-1:0] idx);
        logic [ROW_W-1:0] beat_v;
        beat_v = '0;
`ifdef RESULT_TRANSPOSE_EN
        for (int r = 0; r < ROWS; r++) begin
            beat_v[(ROWS - 1 - r) * ELEM_W +: ELEM_W] = mat[elem_lsb(r, int'(idx)) +: ELEM_W];
        end
`else
        beat_v = mat[row_lsb(int'(idx)) +: ROW_W];
`endif
        return beat_v;
    endfunction

    assign out_valid = (state_q == STREAM);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_last  = out_valid && (row_q == LAST_ROW);
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (row_q == LAST_ROW);
    // A full buffer still takes the matrix when the head's last beat frees a slot this cycle.
    assign capture   = valid_out && (!fifo_full || last_beat);
    assign drop      = valid_out && !capture;

    result_fifo #(
        .DEPTH (DEPTH),
        .W     (MAT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .wdata     (result),
        .pop       (last_beat),
        .head      (fifo_head),
        .next_head (fifo_next_head),
        .full      (fifo_full),
        .has_next  (fifo_has_next)
    );

    // Stream FSM: choose the registered beat for the next cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                // Bypass the incoming matrix so the first beat appears one cycle after valid_out.
                if (capture) begin
                    state_d = STREAM;
                    row_d   = '0;
                    data_d  = beat_of(result, '0);
                end
            end
            STREAM: begin
                if (beat) begin
                    if (row_q != LAST_ROW) begin
                        row_d  = row_q + ROW_ONE;
                        data_d = beat_of(fifo_head, row_q + ROW_ONE);
                    end else begin
                        row_d = '0;
                        if (fifo_has_next) begin
                            data_d = beat_of(fifo_next_head, '0);
                        end else if (capture) begin
                            // The new matrix lands in the FIFO at this edge; take it straight from the input.
                            data_d = beat_of(result, '0);
                        end else begin
                            state_d = IDLE;
                            data_d  = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
                data_d  = '0;
            end
        endcase
    end

    // Drop accounting: sticky overflow flag and saturating drop counter.
    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State, output and accounting registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            data_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
